// File: rtl/bus_master_if.sv
// Single-outstanding bus master: takes one core request at a time, arbitrates for
// the shared bus, runs one address phase and waits for ready, grant loss or timeout.
module bus_master_if #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_rw,
   input  logic [29:0] cpu_addr,
   input  logic [31:0] cpu_wr_data,
   output logic        cpu_busy,
   output logic [31:0] cpu_rd_data,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic        bus_req,
   input  logic        bus_grnt,
   output logic        bus_as,
   output logic        bus_rw,
   output logic [29:0] bus_addr,
   output logic [31:0] bus_wr_data,
   input  logic [31:0] bus_rd_data,
   input  logic        bus_rdy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REQ    = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rw_q, rw_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_inc;
   logic        in_xfer;

   assign cnt_inc = cnt_q + 8'd1;
   assign in_xfer = (state_q == ST_ACCESS) || (state_q == ST_WAIT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req) begin
               rw_d    = cpu_rw;
               addr_d  = cpu_addr;
               wdata_d = cpu_wr_data;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_grnt) begin
               cnt_d   = 8'd0;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS, ST_WAIT: begin
            // Grant loss beats ready; ready beats a coincident timeout.
            if (!bus_grnt) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (bus_rdy) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
               if (rw_q) begin
                  rd_data_d = bus_rd_data;
               end
            end else if (cnt_inc == TIMEOUT) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_inc;
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         rw_q      <= 1'b0;
         addr_q    <= 30'd0;
         wdata_q   <= 32'd0;
         rd_data_q <= 32'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Bus-side signals are gated by state so the bus sees zeros when not transferring.
   assign cpu_busy    = (state_q != ST_IDLE);
   assign bus_req     = (state_q != ST_IDLE);
   assign bus_as      = (state_q == ST_ACCESS);
   assign bus_rw      = in_xfer ? rw_q : 1'b0;
   assign bus_addr    = in_xfer ? addr_q : 30'd0;
   assign bus_wr_data = in_xfer ? wdata_q : 32'd0;
   assign cpu_rd_data = rd_data_q;
   assign cpu_done    = done_q;
   assign cpu_err     = err_q;

endmodule
